// File: rtl/sc_to_binary.sv
// Stochastic-to-binary converter: counts the 1s over a window of 2**WINDOW_LOG2 valid
// stream bits and presents the scaled, saturated estimate on a valid/ready handshake.
module sc_to_binary #(
    parameter int WIDTH       = 8,
    parameter int WINDOW_LOG2 = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             busy,
    output logic [WIDTH-1:0] value,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int CW  = WINDOW_LOG2 + 1;
    localparam int SW  = CW + WIDTH;
    localparam int SHR = (WINDOW_LOG2 >= WIDTH) ? (WINDOW_LOG2 - WIDTH) : 0;
    localparam int SHL = (WINDOW_LOG2 <  WIDTH) ? (WIDTH - WINDOW_LOG2) : 0;
    localparam logic [CW-1:0] LAST_BIT = {1'b0, {WINDOW_LOG2{1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_COUNT,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     ones_q, ones_d;
    logic [CW-1:0]     bit_q, bit_d;
    logic [WIDTH-1:0]  value_q, value_d;
    logic [CW-1:0]     ones_inc;
    logic [CW-1:0]     bit_inc;

    // Only one of SHR/SHL is non-zero; the wide intermediate holds the all-ones count
    // after a left shift so saturation can be detected from its upper bits.
    function automatic logic [WIDTH-1:0] scale(input logic [CW-1:0] n);
        logic [SW-1:0] wide;
        wide = {{WIDTH{1'b0}}, n};
        wide = (wide >> SHR) << SHL;
        if (|wide[SW-1:WIDTH]) begin
            scale = '1;
        end else begin
            scale = wide[WIDTH-1:0];
        end
    endfunction

    assign ones_inc = ones_q + {{WINDOW_LOG2{1'b0}}, bit_in};
    assign bit_inc  = bit_q + {{WINDOW_LOG2{1'b0}}, 1'b1};

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        ones_d  = ones_q;
        bit_d   = bit_q;
        value_d = value_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    ones_d  = '0;
                    bit_d   = '0;
                    state_d = S_COUNT;
                end
            end

            S_COUNT: begin
                if (bit_valid) begin
                    ones_d = ones_inc;
                    bit_d  = bit_inc;
                    if (bit_q == LAST_BIT) begin
                        value_d = scale(ones_inc);
                        state_d = S_DONE;
                    end
                end
            end

            S_DONE: begin
                if (out_ready) begin
                    if (start) begin
                        ones_d  = '0;
                        bit_d   = '0;
                        state_d = S_COUNT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ones_q  <= '0;
            bit_q   <= '0;
            value_q <= '0;
        end else begin
            state_q <= state_d;
            ones_q  <= ones_d;
            bit_q   <= bit_d;
            value_q <= value_d;
        end
    end

    assign busy      = (state_q == S_COUNT);
    assign out_valid = (state_q == S_DONE);
    assign value     = value_q;

endmodule

// File: tb/tb_sc_to_binary.sv
// Directed bench for sc_to_binary: one instance at WINDOW_LOG2=8 and one at
// WINDOW_LOG2=4, with hand-computed expected results.
module tb_sc_to_binary;

    logic       clk;
    logic       rst;

    logic       start, bit_in, bit_valid, out_ready;
    logic       busy, out_valid;
    logic [7:0] value;

    logic       start_s, bit_in_s, bit_valid_s, out_ready_s;
    logic       busy_s, out_valid_s;
    logic [7:0] value_s;

    int checks = 0;
    int errors = 0;

    sc_to_binary #(.WIDTH(8), .WINDOW_LOG2(8)) dut (
        .clk(clk), .rst(rst), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
        .busy(busy), .value(value), .out_valid(out_valid), .out_ready(out_ready)
    );

    sc_to_binary #(.WIDTH(8), .WINDOW_LOG2(4)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .bit_in(bit_in_s), .bit_valid(bit_valid_s),
        .busy(busy_s), .value(value_s), .out_valid(out_valid_s), .out_ready(out_ready_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge and outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bit_in    = b;
        bit_valid = 1'b1;
        step();
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    task automatic send_bit_s(input logic b);
        bit_in_s    = b;
        bit_valid_s = 1'b1;
        step();
        bit_valid_s = 1'b0;
        bit_in_s    = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic accept();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        int sent;
        int cyc;
        logic phase;

        rst = 1'b1;
        start = 0; bit_in = 0; bit_valid = 0; out_ready = 0;
        start_s = 0; bit_in_s = 0; bit_valid_s = 0; out_ready_s = 0;
        step();
        step();
        rst = 1'b0;
        step();
        check("reset_busy", busy, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_value", value, 8'h00);
        check("reset_busy_w4", busy_s, 0);

        // 1: all-zero window, exact 1-cycle latency
        pulse_start();
        check("t1_busy_count", busy, 1);
        for (int i = 0; i < 255; i++) send_bit(1'b0);
        check("t1_not_valid_early", out_valid, 0);
        send_bit(1'b0);
        check("t1_out_valid", out_valid, 1);
        check("t1_busy_done", busy, 0);
        check("t1_value", value, 8'h00);
        accept();
        check("t1_idle_after_accept", out_valid, 0);

        // 2: all-ones window saturates; backpressure holds result
        pulse_start();
        for (int i = 0; i < 256; i++) send_bit(1'b1);
        check("t2_value", value, 8'hFF);
        for (int i = 0; i < 10; i++) begin
            start = (i == 4);
            step();
            check("t2_hold_valid", out_valid, 1);
            check("t2_hold_value", value, 8'hFF);
        end
        start = 1'b0;
        accept();
        check("t2_idle_valid", out_valid, 0);
        check("t2_idle_busy", busy, 0);
        check("t2_value_retained", value, 8'hFF);

        // 3: stray bits in IDLE, alternating stream with gaps
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        check("t3_idle_stray", busy, 0);
        start = 1'b1; bit_in = 1'b1; bit_valid = 1'b1;
        step();
        start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
        sent = 0;
        cyc = 0;
        phase = 1'b1;
        while (sent < 256 && cyc < 1000) begin
            if (cyc % 3 == 2) begin
                bit_in = 1'b1;
                bit_valid = 1'b0;
                step();
                bit_in = 1'b0;
            end else begin
                send_bit(phase);
                phase = ~phase;
                sent++;
            end
            cyc++;
        end
        check("t3_bits_sent", sent, 256);
        check("t3_out_valid", out_valid, 1);
        check("t3_value", value, 8'h80);
        accept();

        // 4: rst mid-window discards partial count
        pulse_start();
        for (int i = 0; i < 100; i++) send_bit(1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t4_rst_busy", busy, 0);
        check("t4_rst_out_valid", out_valid, 0);
        check("t4_rst_value", value, 8'h00);
        pulse_start();
        for (int i = 0; i < 256; i++) send_bit(i < 64);
        check("t4_out_valid", out_valid, 1);
        check("t4_value", value, 8'h40);
        accept();

        // 5: accept and restart in the same cycle
        pulse_start();
        for (int i = 0; i < 256; i++) send_bit(i < 32);
        check("t5_first_value", value, 8'h20);
        out_ready = 1'b1; start = 1'b1;
        step();
        out_ready = 1'b0; start = 1'b0;
        check("t5_restart_busy", busy, 1);
        check("t5_restart_out_valid", out_valid, 0);
        for (int i = 0; i < 256; i++) send_bit((i % 4) != 3);
        check("t5_out_valid", out_valid, 1);
        check("t5_value", value, 8'hC0);
        accept();

        // 6: 16-bit window, left-shift scaling, start ignored in COUNT
        start_s = 1'b1;
        step();
        start_s = 1'b0;
        for (int i = 0; i < 8; i++) send_bit_s(i < 3);
        start_s = 1'b1;
        step();
        start_s = 1'b0;
        check("t6_start_ignored", busy_s, 1);
        for (int i = 0; i < 7; i++) send_bit_s(i < 2);
        check("t6_not_valid_early", out_valid_s, 0);
        send_bit_s(1'b0);
        check("t6_out_valid", out_valid_s, 1);
        check("t6_value_5", value_s, 8'h50);
        out_ready_s = 1'b1;
        step();
        out_ready_s = 1'b0;
        start_s = 1'b1;
        step();
        start_s = 1'b0;
        for (int i = 0; i < 16; i++) send_bit_s(1'b1);
        check("t6_value_16", value_s, 8'hFF);
        check("t6_busy_done", busy_s, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
